dm163_scan_ctrl: RTL and testbench
==================================

# dm163_scan_ctrl

Scan controller for the 8×8 RGB colorshield, driven by the DM163 constant-current driver. After reset it initialises the DM163 gamma bank. It then scans the pixel grid's eight columns continuously. For each column it:
- reads the column's 192-bit word,
- serialises the word into the DM163,
- latches it,
- enables the matching column driver for a fixed display time.

The block sits between the pixel grid storage and the shield pins.

## Interface
- HOLD_CYCLES, 1000: clk cycles each column stays lit (≥1).
- RST_CYCLES, 8: clk cycles the DM163 reset is held low after rst_n release (≥1).
- GAMMA_VALUE, 6'h3F: 6-bit value written to all 24 bank-0 (gamma) channels.
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  scanning allowed; sampled at column boundaries.
- col_bits  in  192  grid read data for col_idx; combinational, valid in the same cycle.
- col_idx  out  3  column address to the grid.
- dm_rst_n  out  1  DM163 reset, active-low.
- dm_sb  out  1  DM163 bank select: 0 = gamma bank, 1 = PWM bank.
- dm_sck  out  1  DM163 serial clock; data sampled on its rising edge.
- dm_sda  out  1  DM163 serial data.
- dm_lat  out  1  DM163 latch, 1-cycle high pulse.
- channel_en  out  8  one-hot column driver enable.
- ready  out  1  high once gamma init is complete.
- frame_done  out  1  1-cycle pulse after column 7 finishes its display time.

## Operation
- States: DM_RST → GAMMA_SHIFT → GAMMA_LATCH → IDLE → LOAD → SHIFT → LATCH → SHOW → (LOAD | IDLE).
- **DM_RST**
  - dm_rst_n=0 for RST_CYCLES, then dm_rst_n=1 permanently.
  - Next state: GAMMA_SHIFT.
- **GAMMA_SHIFT**
  - dm_sb=0; shifts 144 bits, i.e. GAMMA_VALUE repeated 24 times.
  - Bit order: MSB first per channel.
- **GAMMA_LATCH**
  - One lat pulse.
  - dm_sb then goes to 1 and stays 1.
  - ready rises the following cycle and stays high.
- **IDLE**
  - channel_en=0, col counter=0.
  - Goes to LOAD when enable=1.
- **LOAD** (1 cycle)
  - col_idx=col counter.
  - col_bits captured into the 192-bit shift register at the clock edge.
- **SHIFT**
  - 192 bits, col_bits[191] first, col_bits[0] last.
  - The previous column stays lit during SHIFT (channel_en unchanged).
- **LATCH** (1 cycle)
  - channel_en=0 (blanking); dm_lat=1.
- **SHOW** (HOLD_CYCLES)
  - channel_en = 1<<col.
  - On the final cycle:
    - If col==7: frame_done=1 and col wraps to 0.
    - Otherwise col increments.
  - Next state: LOAD if enable=1, else IDLE.
- enable is not sampled mid-column. When enable=0 at a boundary, the block blanks in IDLE and the next scan restarts at column 0.
- Grid writes during a scan are not blocked; a column shows whatever was captured at its LOAD (tearing accepted).
- rst_n asserted at any point:
  - all outputs go immediately to their reset values;
  - the full init sequence reruns, including the gamma write.

## Timing
- Reset values:
  - dm_rst_n=0, dm_sb=0, dm_sck=0, dm_sda=0, dm_lat=0;
  - channel_en=0, col_idx=0, ready=0, frame_done=0.
- All outputs are registered.
- Serial bit n takes 2 cycles:
  - cycle A: sck=0, sda=bit;
  - cycle B: sck=1, sda held.
- sck idles low outside shift states.
- Durations:
  - SHIFT = 384 cycles; GAMMA_SHIFT = 288 cycles.
- Per column = 1 + 384 + 1 + HOLD_CYCLES cycles, i.e. 1386 at default; frame = 8× that (11088 cycles).
- Init: ready rises RST_CYCLES + 288 + 2 cycles after rst_n release.
- dm_lat is high only in cycles with sck=0 and no shifting.
- channel_en is 0 in every cycle where dm_lat=1.

## Structure
- Package dm163_pkg holds:
  - N_COLS=8, BITS_PER_PIXEL=24, COL_BITS=192, GAMMA_BITS=144;
  - the state enum.
- Sub-module dm163_shifter, a generic serialiser:
  - inputs: load, 192-bit data, bit count (144/192), start;
  - outputs: sck, sda, done (1-cycle).
  - It is reused for both GAMMA_SHIFT and SHIFT.
- The top-level FSM owns the counters: RST_CYCLES, HOLD_CYCLES, col.

## Test plan
- **Reset/init:** release rst_n with RST_CYCLES=8.
  - dm_rst_n low for exactly 8 cycles.
  - Then 144 sck rises with dm_sb=0 and sda all 1s, one lat pulse.
  - ready high at cycle 298.
- **Single column:** col 0 word = 192'h1 (only bit 0 set), enable=1, HOLD_CYCLES=4.
  - 192 sck rises; sda=1 only on the 192nd.
  - lat pulse with channel_en=0, then channel_en=8'h01 for 4 cycles.
- **Full frame:** distinct pattern per column, HOLD_CYCLES=4.
  - col_idx sequence 0..7.
  - channel_en 01,02,…,80.
  - frame_done pulses once after col 7.
  - Frame length = 8×390 cycles.
- **Enable drop:** deassert enable during SHIFT of col 3.
  - Col 3 completes its SHOW, then IDLE with channel_en=0.
  - Re-enable → next LOAD uses col_idx=0.
- **Mid-operation reset:** assert rst_n during SHOW of col 5.
  - Outputs are immediately at reset values.
  - Gamma init repeats; ready low until it completes.

Source files
------------

// File: rtl/dm163_pkg.sv
`default_nettype none
// ============================================================================
// dm163_pkg : shared geometry constants, scan state encoding, gamma word builder
// Revision  : 1.0
// ============================================================================
package dm163_pkg;

  localparam int N_COLS         = 8;
  localparam int BITS_PER_PIXEL = 24;
  localparam int COL_BITS       = N_COLS * BITS_PER_PIXEL;
  localparam int GAMMA_CH       = 24;
  localparam int GAMMA_BITS     = GAMMA_CH * 6;

  typedef enum logic [2:0] {
    ST_DM_RST,
    ST_GAMMA_SHIFT,
    ST_GAMMA_LATCH,
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_SHOW
  } state_t;

  // Gamma pattern left-aligned so the shifter can always start from the MSB.
  function automatic logic [COL_BITS-1:0] gamma_word(input logic [5:0] value);
    logic [COL_BITS-1:0] w;
    w = '0;
    for (int i = 0; i < GAMMA_CH; i++) begin
      w[COL_BITS-1-6*i -: 6] = value;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm163_shifter.sv
`default_nettype none
// ============================================================================
// dm163_shifter : MSB-first serialiser, two clk cycles per bit (sck low, high)
// Revision      : 1.0
// ============================================================================
module dm163_shifter
  import dm163_pkg::*;
#(
  parameter int WIDTH = COL_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [7:0]       bit_count,
  input  logic             start,
  output logic             sck,
  output logic             sda,
  output logic             done
);

  logic [WIDTH-1:0] shreg;
  logic [7:0]       remaining;
  logic             busy;
  logic             phase_a;

  // done is high during the final sck-high cycle so the caller can latch
  // on the very next cycle with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      phase_a   <= 1'b0;
      sck       <= 1'b0;
      sda       <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        shreg <= data;
      end
      if (start) begin
        busy      <= 1'b1;
        phase_a   <= 1'b1;
        sck       <= 1'b0;
        sda       <= load ? data[WIDTH-1] : shreg[WIDTH-1];
        remaining <= bit_count - 8'd1;
      end else if (busy) begin
        if (phase_a) begin
          sck     <= 1'b1;
          phase_a <= 1'b0;
          if (remaining == 8'd0) begin
            done <= 1'b1;
          end
        end else if (remaining == 8'd0) begin
          busy <= 1'b0;
          sck  <= 1'b0;
          sda  <= 1'b0;
        end else begin
          shreg     <= shreg << 1;
          sda       <= shreg[WIDTH-2];
          sck       <= 1'b0;
          phase_a   <= 1'b1;
          remaining <= remaining - 8'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dm163_scan_ctrl.sv
`default_nettype none
// ============================================================================
// dm163_scan_ctrl : DM163 gamma init then continuous 8-column colorshield scan
// Revision        : 1.0
// ============================================================================
module dm163_scan_ctrl
  import dm163_pkg::*;
#(
  parameter int          HOLD_CYCLES = 1000,
  parameter int          RST_CYCLES  = 8,
  parameter logic [5:0]  GAMMA_VALUE = 6'h3F
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [COL_BITS-1:0] col_bits,
  output logic [2:0]          col_idx,
  output logic                dm_rst_n,
  output logic                dm_sb,
  output logic                dm_sck,
  output logic                dm_sda,
  output logic                dm_lat,
  output logic [7:0]          channel_en,
  output logic                ready,
  output logic                frame_done
);

  localparam int CNT_MAX = (HOLD_CYCLES > RST_CYCLES) ? HOLD_CYCLES : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          col;
  logic [2:0]          next_col;
  logic                last_col;
  logic                sh_start;
  logic                sh_done;
  logic [COL_BITS-1:0] sh_data;
  logic [7:0]          sh_bits;

  assign last_col = (col == 3'(N_COLS - 1));
  assign next_col = last_col ? 3'd0 : col + 3'd1;

  // Gamma shift starts on the same edge that releases the DM163 reset.
  assign sh_start = ((state == ST_DM_RST) && (cnt == CNT_W'(RST_CYCLES - 1)))
                  || (state == ST_LOAD);
  assign sh_data  = (state == ST_DM_RST) ? gamma_word(GAMMA_VALUE) : col_bits;
  assign sh_bits  = (state == ST_DM_RST) ? 8'(GAMMA_BITS) : 8'(COL_BITS);

  dm163_shifter #(
    .WIDTH (COL_BITS)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sh_start),
    .data      (sh_data),
    .bit_count (sh_bits),
    .start     (sh_start),
    .sck       (dm_sck),
    .sda       (dm_sda),
    .done      (sh_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_DM_RST;
      cnt        <= '0;
      col        <= 3'd0;
      col_idx    <= 3'd0;
      dm_rst_n   <= 1'b0;
      dm_sb      <= 1'b0;
      dm_lat     <= 1'b0;
      channel_en <= 8'd0;
      ready      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        ST_DM_RST: begin
          if (cnt == CNT_W'(RST_CYCLES - 1)) begin
            cnt      <= '0;
            dm_rst_n <= 1'b1;
            state    <= ST_GAMMA_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAMMA_SHIFT: begin
          if (sh_done) begin
            dm_lat <= 1'b1;
            state  <= ST_GAMMA_LATCH;
          end
        end
        ST_GAMMA_LATCH: begin
          dm_lat <= 1'b0;
          dm_sb  <= 1'b1;
          state  <= ST_IDLE;
        end
        ST_IDLE: begin
          ready      <= 1'b1;
          channel_en <= 8'd0;
          col        <= 3'd0;
          col_idx    <= 3'd0;
          if (enable) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // Previous column stays lit until the new data is latched.
          if (sh_done) begin
            dm_lat     <= 1'b1;
            channel_en <= 8'd0;
            state      <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          dm_lat     <= 1'b0;
          channel_en <= 8'b1 << col;
          cnt        <= '0;
          state      <= ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            cnt        <= '0;
            frame_done <= last_col;
            if (enable) begin
              col     <= next_col;
              col_idx <= next_col;
              state   <= ST_LOAD;
            end else begin
              col        <= 3'd0;
              col_idx    <= 3'd0;
              channel_en <= 8'd0;
              state      <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_DM_RST;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm163_scan_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dm163_scan_ctrl : scoreboard bench -- expected pin events queued, monitor compares
// Revision           : 1.0
// ============================================================================
module tb_dm163_scan_ctrl;

  localparam int         HOLD = 4;
  localparam int         RSTC = 8;
  localparam logic [5:0] GV   = 6'h3F;

  localparam logic [3:0] K_RSTHI = 4'd1, K_BIT = 4'd2, K_EN = 4'd3,
                         K_LAT   = 4'd4, K_FD  = 4'd5, K_RDY = 4'd6;

  typedef struct packed {
    logic [3:0] kind;
    logic [7:0] a;
    logic [7:0] b;
    int         cyc;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [191:0] col_bits;
  logic [2:0]   col_idx;
  logic         dm_rst_n, dm_sb, dm_sck, dm_sda, dm_lat, ready, frame_done;
  logic [7:0]   channel_en;

  logic [191:0] grid [8];
  ev_t          sb_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           t0 = 0;

  logic p_sck, p_rst, p_rdy;
  logic [7:0] p_en;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign col_bits = grid[col_idx];

  dm163_scan_ctrl #(
    .HOLD_CYCLES (HOLD),
    .RST_CYCLES  (RSTC),
    .GAMMA_VALUE (GV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .col_bits   (col_bits),
    .col_idx    (col_idx),
    .dm_rst_n   (dm_rst_n),
    .dm_sb      (dm_sb),
    .dm_sck     (dm_sck),
    .dm_sda     (dm_sda),
    .dm_lat     (dm_lat),
    .channel_en (channel_en),
    .ready      (ready),
    .frame_done (frame_done)
  );

  function automatic string kname(input logic [3:0] k);
    case (k)
      K_RSTHI: return "dm_rst_n_rise";
      K_BIT:   return "sck_rise_bit";
      K_EN:    return "channel_en_change";
      K_LAT:   return "lat_pulse";
      K_FD:    return "frame_done";
      K_RDY:   return "ready_rise";
      default: return "unknown";
    endcase
  endfunction

  function automatic void push(input logic [3:0] k, input logic [7:0] a,
                               input logic [7:0] b, input int c);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.cyc = c;
    sb_q.push_back(e);
  endfunction

  // Gamma init: dm_rst_n rises at cycle RSTC, bits rise every 2 cycles, lat, ready.
  function automatic void push_gamma();
    logic [5:0] g;
    g = GV;
    push(K_RSTHI, 8'h00, 8'h00, RSTC);
    for (int i = 0; i < 144; i++) begin
      push(K_BIT, {6'b0, 1'b0, g[5 - (i % 6)]}, 8'h00, RSTC + 1 + 2 * i);
    end
    push(K_LAT, 8'h00, 8'h00, RSTC + 288);
    push(K_RDY, 8'h00, 8'h00, RSTC + 290);
  endfunction

  // One column whose LOAD cycle is s; bits MSB first with dm_sb=1.
  function automatic void push_col(input int c, input int s, input logic [7:0] prev_en,
                                   input logic [191:0] word);
    logic [7:0] en;
    en = 8'b1 << c;
    for (int i = 0; i < 192; i++) begin
      push(K_BIT, {6'b0, 1'b1, word[191 - i]}, 8'h00, s + 2 + 2 * i);
    end
    if (prev_en != 8'h00) push(K_EN, 8'h00, 8'h00, s + 385);
    push(K_LAT, 8'h00, {4'b0, 1'b0, 3'(c)}, s + 385);
    push(K_EN, en, 8'h00, s + 386);
  endfunction

  task automatic observe(input logic [3:0] k, input logic [7:0] a,
                         input logic [7:0] b, input int c);
    ev_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got a=%h b=%h at cycle %0d, required no event",
               kname(k), a, b, c);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != k || e.a != a || e.b != b || e.cyc != c) begin
        errors++;
        $display("FAIL %s: got %s a=%h b=%h cyc=%0d, required %s a=%h b=%h cyc=%0d",
                 kname(e.kind), kname(k), a, b, c, kname(e.kind), e.a, e.b, e.cyc);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic wait_rel(input int n);
    do begin
      @(posedge clk);
      #1;
    end while (cyc - t0 < n);
  endtask

  // Monitor: turns pin activity into events in a fixed per-cycle order.
  always @(negedge clk) begin
    if (!rst_n) begin
      p_sck = 1'b0;
      p_rst = dm_rst_n;
      p_rdy = ready;
      p_en  = channel_en;
    end else begin
      if (dm_rst_n && !p_rst)    observe(K_RSTHI, 8'h00, 8'h00, cyc - t0);
      if (dm_sck && !p_sck)      observe(K_BIT, {6'b0, dm_sb, dm_sda}, 8'h00, cyc - t0);
      if (channel_en != p_en)    observe(K_EN, channel_en, 8'h00, cyc - t0);
      if (dm_lat)                observe(K_LAT, channel_en, {4'b0, dm_sck, col_idx}, cyc - t0);
      if (frame_done)            observe(K_FD, 8'h00, 8'h00, cyc - t0);
      if (ready && !p_rdy)       observe(K_RDY, 8'h00, 8'h00, cyc - t0);
      p_sck = dm_sck;
      p_rst = dm_rst_n;
      p_rdy = ready;
      p_en  = channel_en;
    end
  end

  function automatic logic [191:0] pattern(input int c);
    logic [31:0] w;
    w = 32'hC0DE0000 | (32'(c) << 12) | (32'(c) << 4) | 32'(c);
    return {6{w}};
  endfunction

  initial begin
    int s;
    logic [7:0] pe;
    rst_n  = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) grid[i] = 192'h0;
    grid[0] = 192'h1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {14'b0, dm_rst_n, dm_sb, dm_sck, dm_sda, dm_lat,
                            channel_en, col_idx, ready, frame_done}, 32'h0);

    // Init plus a single column, enable dropped during its shift.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    t0    = cyc;
    push_gamma();
    push_col(0, 298, 8'h00, grid[0]);
    push(K_EN, 8'h00, 8'h00, 688);
    wait_rel(500);
    enable = 1'b0;

    // Full frame plus second frame stopped after column 3.
    wait_rel(690);
    for (int i = 0; i < 8; i++) grid[i] = pattern(i);
    pe = 8'h00;
    for (int c = 0; c < 8; c++) begin
      s = 701 + 390 * c;
      push_col(c, s, pe, grid[c]);
      pe = 8'b1 << c;
    end
    push(K_FD, 8'h00, 8'h00, 701 + 8 * 390);
    for (int c = 0; c < 4; c++) begin
      s = 3821 + 390 * c;
      push_col(c, s, pe, grid[c]);
      pe = 8'b1 << c;
    end
    push(K_EN, 8'h00, 8'h00, 3821 + 3 * 390 + 390);
    wait_rel(700);
    enable = 1'b1;
    wait_rel(5100);
    enable = 1'b0;

    // Restart at column 0, then reset during column 5 display.
    pe = 8'h00;
    for (int c = 0; c < 6; c++) begin
      s = 5501 + 390 * c;
      push_col(c, s, pe, grid[c]);
      pe = 8'b1 << c;
    end
    wait_rel(5500);
    enable = 1'b1;
    wait_rel(7838);
    check("show_col5_before_reset", {24'b0, channel_en}, 32'h20);
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check("midreset_outputs", {14'b0, dm_rst_n, dm_sb, dm_sck, dm_sda, dm_lat,
                               channel_en, col_idx, ready, frame_done}, 32'h0);
    check("events_pending_at_reset", sb_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    t0    = cyc;
    push_gamma();
    wait_rel(200);
    check("ready_low_during_reinit", {31'b0, ready}, 32'h0);
    wait_rel(320);
    check("idle_blank_after_reinit", {23'b0, ready, channel_en}, 32'h100);

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
    check("events_pending_at_end", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
